// File: rtl/cp0_ext.sv
// cp0_ext: MIPS-style coprocessor 0 subset (BadVAddr, Count, Compare, Status, Cause, EPC).
// Optional feature macro: CP0_TIMER_INT_EN adds the Compare register and the Cause.TI timer interrupt.
// Without it Compare reads 0, writes are ignored, TI is constant 0 and Count still runs.
module cp0_ext #(
   parameter int WIDTH      = 32,
   parameter int HW_INT_NUM = 6,
   parameter int COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mtc0_we,
   input  logic [4:0]            mtc0_addr,
   input  logic [WIDTH-1:0]      mtc0_wdata,
   input  logic [4:0]            mfc0_addr,
   output logic [WIDTH-1:0]      mfc0_rdata,
   input  logic [HW_INT_NUM-1:0] hw_int,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic                  exc_bd,
   input  logic [WIDTH-1:0]      exc_pc,
   input  logic                  exc_badv_we,
   input  logic [WIDTH-1:0]      exc_badvaddr,
   input  logic                  eret,
   output logic                  int_req,
   output logic [WIDTH-1:0]      status_out,
   output logic [WIDTH-1:0]      cause_out,
   output logic [WIDTH-1:0]      epc_out
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic             ie_q, ie_d;
   logic             exl_q, exl_d;
   logic [7:0]       im_q, im_d;
   logic             bd_q, bd_d;
   logic [1:0]       swIp_q, swIp_d;
   logic [5:0]       hwIp_q, hwIp_d;
   logic [4:0]       excCode_q, excCode_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] badVAddr_q, badVAddr_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic             intReq_q, intReq_d;
   logic             tiBit;
   logic [7:0]       ip;
   logic [WIDTH-1:0] compareWord;
   logic             wrStatus, wrCause, wrEpc, wrCount, wrCompare;
   logic             divWrap;

`ifdef CP0_TIMER_INT_EN
   logic [WIDTH-1:0] compare_q, compare_d;
   logic             ti_q, ti_d;
   assign tiBit       = ti_q;
   assign compareWord = compare_q;
`else
   assign tiBit       = 1'b0;
   assign compareWord = '0;
`endif

   // Software writes lose to exception/eret only on the registers those events touch
   assign wrStatus  = mtc0_we && (mtc0_addr == 5'd12) && !exc_valid && !eret;
   assign wrCause   = mtc0_we && (mtc0_addr == 5'd13) && !exc_valid;
   assign wrEpc     = mtc0_we && (mtc0_addr == 5'd14) && !exc_valid;
   assign wrCount   = mtc0_we && (mtc0_addr == 5'd9);
   assign wrCompare = mtc0_we && (mtc0_addr == 5'd11);
   assign divWrap   = (divCnt_q == DIV_W'(COUNT_DIV - 1));

   // IP7 is shared between the timer and hardware line 5
   assign ip = {tiBit | hwIp_q[5], hwIp_q[4:0], swIp_q};

   // Assemble the architecturally visible Status/Cause/EPC words
   always_comb begin
      status_out     = '0;
      status_out[22] = 1'b1;
      status_out[15:8] = im_q;
      status_out[1]  = exl_q;
      status_out[0]  = ie_q;
      cause_out      = '0;
      cause_out[31]  = bd_q;
      cause_out[30]  = tiBit;
      cause_out[15:8] = ip;
      cause_out[6:2] = excCode_q;
      epc_out        = epc_q;
   end

   // Register read mux; reflects state before the current edge
   always_comb begin
      mfc0_rdata = '0;
      case (mfc0_addr)
         5'd8:    mfc0_rdata = badVAddr_q;
         5'd9:    mfc0_rdata = count_q;
         5'd11:   mfc0_rdata = compareWord;
         5'd12:   mfc0_rdata = status_out;
         5'd13:   mfc0_rdata = cause_out;
         5'd14:   mfc0_rdata = epc_out;
         default: mfc0_rdata = '0;
      endcase
   end

   // Next-state for all CP0 registers: exception beats eret beats software write
   always_comb begin
      ie_d       = ie_q;
      exl_d      = exl_q;
      im_d       = im_q;
      bd_d       = bd_q;
      swIp_d     = swIp_q;
      excCode_d  = excCode_q;
      epc_d      = epc_q;
      badVAddr_d = badVAddr_q;
      count_d    = count_q;
      divCnt_d   = divCnt_q;
      hwIp_d     = '0;
      for (int i = 0; i < HW_INT_NUM; i++) begin
         hwIp_d[i] = hw_int[i];
      end
      if (wrCount) begin
         count_d  = mtc0_wdata;
         divCnt_d = '0;
      end else if (divWrap) begin
         count_d  = count_q + WIDTH'(1);
         divCnt_d = '0;
      end else begin
         divCnt_d = divCnt_q + DIV_W'(1);
      end
      if (wrStatus) begin
         im_d  = mtc0_wdata[15:8];
         exl_d = mtc0_wdata[1];
         ie_d  = mtc0_wdata[0];
      end
      if (wrCause) begin
         swIp_d = mtc0_wdata[9:8];
      end
      if (wrEpc) begin
         epc_d = mtc0_wdata;
      end
      if (exc_valid) begin
         excCode_d = exc_code;
         if (!exl_q) begin
            exl_d = 1'b1;
            bd_d  = exc_bd;
            epc_d = exc_bd ? (exc_pc - WIDTH'(4)) : exc_pc;
         end
         if (exc_badv_we) begin
            badVAddr_d = exc_badvaddr;
         end
      end else if (eret) begin
         exl_d = 1'b0;
      end
      intReq_d = ie_q & ~exl_q & (|(ip & im_q));
   end

`ifdef CP0_TIMER_INT_EN
   // Timer match sets TI; a Compare write clears it and wins over a same-cycle match
   always_comb begin
      compare_d = compare_q;
      ti_d      = ti_q;
      if (wrCompare) begin
         compare_d = mtc0_wdata;
         ti_d      = 1'b0;
      end else if (count_q == compare_q) begin
         ti_d = 1'b1;
      end
   end

   // Timer state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end
`else
   logic unusedCompareWr;
   assign unusedCompareWr = wrCompare;
`endif

   // Core CP0 state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= '0;
         bd_q       <= 1'b0;
         swIp_q     <= '0;
         hwIp_q     <= '0;
         excCode_q  <= '0;
         epc_q      <= '0;
         badVAddr_q <= '0;
         count_q    <= '0;
         divCnt_q   <= '0;
         intReq_q   <= 1'b0;
      end else begin
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         bd_q       <= bd_d;
         swIp_q     <= swIp_d;
         hwIp_q     <= hwIp_d;
         excCode_q  <= excCode_d;
         epc_q      <= epc_d;
         badVAddr_q <= badVAddr_d;
         count_q    <= count_d;
         divCnt_q   <= divCnt_d;
         intReq_q   <= intReq_d;
      end
   end

   assign int_req = intReq_q;

endmodule

// File: tb/tb_cp0_ext.sv
// Testbench for cp0_ext (default parameters: WIDTH=32, HW_INT_NUM=6, COUNT_DIV=2).
// Register write/read vectors come from a table; multi-cycle behaviour uses hand sequences.
// Expected values are queued when stimulus is driven and popped when outputs are sampled.
module tb_cp0_ext;

   logic        clk;
   logic        rst;
   logic        mtc0_we;
   logic [4:0]  mtc0_addr;
   logic [31:0] mtc0_wdata;
   logic [4:0]  mfc0_addr;
   logic [31:0] mfc0_rdata;
   logic [5:0]  hw_int;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        exc_bd;
   logic [31:0] exc_pc;
   logic        exc_badv_we;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic        int_req;
   logic [31:0] status_out;
   logic [31:0] cause_out;
   logic [31:0] epc_out;

   int errorCount = 0;
   int checkCount = 0;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic [31:0] exp;
      logic [31:0] mask;
   } vecT;

   typedef struct {
      string       name;
      int          sel;
      logic [4:0]  addr;
      logic [31:0] exp;
      logic [31:0] mask;
   } expT;

   localparam int SEL_RD = 0, SEL_INT = 1, SEL_STATUS = 2, SEL_CAUSE = 3, SEL_EPC = 4;
   localparam logic [31:0] NO_TI = 32'hBFFF_FFFF;
   localparam logic [31:0] ALL   = 32'hFFFF_FFFF;

   expT expQ[$];
   vecT vecs[12];

   cp0_ext dut (
      .clk(clk),
      .rst(rst),
      .mtc0_we(mtc0_we),
      .mtc0_addr(mtc0_addr),
      .mtc0_wdata(mtc0_wdata),
      .mfc0_addr(mfc0_addr),
      .mfc0_rdata(mfc0_rdata),
      .hw_int(hw_int),
      .exc_valid(exc_valid),
      .exc_code(exc_code),
      .exc_bd(exc_bd),
      .exc_pc(exc_pc),
      .exc_badv_we(exc_badv_we),
      .exc_badvaddr(exc_badvaddr),
      .eret(eret),
      .int_req(int_req),
      .status_out(status_out),
      .cause_out(cause_out),
      .epc_out(epc_out)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void pushExp(string name, int sel, logic [4:0] addr,
                                   logic [31:0] exp, logic [31:0] mask);
      expT e;
      e.name = name;
      e.sel  = sel;
      e.addr = addr;
      e.exp  = exp;
      e.mask = mask;
      expQ.push_back(e);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drain the scoreboard against the current outputs (called while the clock is low)
   task automatic checkOutput();
      expT         e;
      logic [31:0] act;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         act = '0;
         case (e.sel)
            SEL_RD: begin
               mfc0_addr = e.addr;
               #1;
               act = mfc0_rdata;
            end
            SEL_INT:    act = {31'b0, int_req};
            SEL_STATUS: act = status_out;
            SEL_CAUSE:  act = cause_out;
            SEL_EPC:    act = epc_out;
            default:    act = '0;
         endcase
         checkCount++;
         if ((act & e.mask) !== (e.exp & e.mask)) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)",
                     e.name, act & e.mask, e.exp & e.mask, e.mask);
         end
      end
   endtask

   // One software write for one cycle, then compare the read-back
   task automatic applyStimulus(input vecT v);
      mtc0_we    = v.we;
      mtc0_addr  = v.waddr;
      mtc0_wdata = v.wdata;
      pushExp(v.name, SEL_RD, v.raddr, v.exp, v.mask);
      tick(1);
      mtc0_we = 1'b0;
      checkOutput();
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      mtc0_we    = 1'b1;
      mtc0_addr  = addr;
      mtc0_wdata = data;
      tick(1);
      mtc0_we = 1'b0;
   endtask

   task automatic doExc(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                        input logic bvWe, input logic [31:0] bv);
      exc_valid    = 1'b1;
      exc_bd       = bd;
      exc_pc       = pc;
      exc_code     = code;
      exc_badv_we  = bvWe;
      exc_badvaddr = bv;
      tick(1);
      exc_valid   = 1'b0;
      exc_badv_we = 1'b0;
   endtask

   task automatic setVec(input int i, input string name, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [31:0] exp,
                         input logic [31:0] mask);
      vecs[i].name  = name;
      vecs[i].we    = we;
      vecs[i].waddr = wa;
      vecs[i].wdata = wd;
      vecs[i].raddr = ra;
      vecs[i].exp   = exp;
      vecs[i].mask  = mask;
   endtask

   // Main test sequence
   initial begin
      rst = 1'b1;
      mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0; mfc0_addr = '0;
      hw_int = '0; exc_valid = 1'b0; exc_code = '0; exc_bd = 1'b0; exc_pc = '0;
      exc_badv_we = 1'b0; exc_badvaddr = '0; eret = 1'b0;

      setVec(0,  "status_all",    1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03, ALL);
      setVec(1,  "status_im7_ie", 1'b1, 5'd12, 32'h0000_8001, 5'd12, 32'h0040_8001, ALL);
      setVec(2,  "cause_sw_ip",   1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300, NO_TI);
      setVec(3,  "cause_clear",   1'b1, 5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000, NO_TI);
      setVec(4,  "epc_write",     1'b1, 5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678, ALL);
      setVec(5,  "badv_ro",       1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  32'h0000_0000, ALL);
      setVec(6,  "unmapped_reg",  1'b1, 5'd3,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, ALL);
`ifdef CP0_TIMER_INT_EN
      setVec(7,  "compare_write", 1'b1, 5'd11, 32'h0000_0005, 5'd11, 32'h0000_0005, ALL);
`else
      setVec(7,  "compare_absent", 1'b1, 5'd11, 32'h0000_0005, 5'd11, 32'h0000_0000, ALL);
`endif
      setVec(8,  "count_load",    1'b1, 5'd9,  32'h0000_0100, 5'd9,  32'h0000_0100, ALL);
      setVec(9,  "epc_clear",     1'b1, 5'd14, 32'h0000_0000, 5'd14, 32'h0000_0000, ALL);
      setVec(10, "status_clear",  1'b1, 5'd12, 32'h0000_0000, 5'd12, 32'h0040_0000, ALL);
      setVec(11, "reg31_zero",    1'b0, 5'd31, 32'h0000_0000, 5'd31, 32'h0000_0000, ALL);

      // Reset state
      tick(1);
      pushExp("rst_status", SEL_RD, 5'd12, 32'h0040_0000, ALL);
      pushExp("rst_count", SEL_RD, 5'd9, 32'h0, ALL);
      pushExp("rst_int", SEL_INT, 5'd0, 32'h0, 32'h1);
      pushExp("rst_epc", SEL_EPC, 5'd0, 32'h0, ALL);
      pushExp("rst_cause", SEL_CAUSE, 5'd0, 32'h0, NO_TI);
      checkOutput();
      rst = 1'b0;
      tick(10);
      pushExp("count_after_10", SEL_RD, 5'd9, 32'd5, ALL);
      checkOutput();

      // Table-driven register access
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
      end

      // Count wrap
      mtc0(5'd9, 32'hFFFF_FFFE);
      pushExp("count_wr", SEL_RD, 5'd9, 32'hFFFF_FFFE, ALL);
      checkOutput();
      tick(2);
      pushExp("count_ffff", SEL_RD, 5'd9, 32'hFFFF_FFFF, ALL);
      checkOutput();
      tick(2);
      pushExp("count_wrap0", SEL_RD, 5'd9, 32'h0, ALL);
      checkOutput();

      // Exception entry in a delay slot, then nested exception
      doExc(1'b1, 32'hBFC0_0104, 5'd4, 1'b0, 32'h1111_1111);
      pushExp("exc1_epc", SEL_RD, 5'd14, 32'hBFC0_0100, ALL);
      pushExp("exc1_cause", SEL_RD, 5'd13, 32'h8000_0010, NO_TI);
      pushExp("exc1_badv_hold", SEL_RD, 5'd8, 32'h0, ALL);
      pushExp("exc1_status", SEL_STATUS, 5'd0, 32'h0040_0002, ALL);
      checkOutput();
      doExc(1'b0, 32'h0000_1000, 5'd5, 1'b1, 32'hCAFE_0000);
      pushExp("exc2_epc", SEL_RD, 5'd14, 32'hBFC0_0100, ALL);
      pushExp("exc2_cause", SEL_RD, 5'd13, 32'h8000_0014, NO_TI);
      pushExp("exc2_badv", SEL_RD, 5'd8, 32'hCAFE_0000, ALL);
      checkOutput();

      // eret and write priority
      eret = 1'b1;
      tick(1);
      eret = 1'b0;
      pushExp("eret_status", SEL_STATUS, 5'd0, 32'h0040_0000, ALL);
      checkOutput();
      mtc0(5'd12, 32'h0000_0001);
      pushExp("status_ie", SEL_STATUS, 5'd0, 32'h0040_0001, ALL);
      checkOutput();
      mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_wdata = 32'h0;
      doExc(1'b0, 32'h0000_2000, 5'd8, 1'b0, 32'h0);
      mtc0_we = 1'b0;
      pushExp("exc_beats_mtc0", SEL_STATUS, 5'd0, 32'h0040_0003, ALL);
      pushExp("exc3_epc", SEL_EPC, 5'd0, 32'h0000_2000, ALL);
      pushExp("exc3_cause", SEL_CAUSE, 5'd0, 32'h0000_0020, NO_TI);
      checkOutput();
      eret = 1'b1;
      mtc0(5'd12, 32'h0000_FF01);
      eret = 1'b0;
      pushExp("eret_beats_mtc0", SEL_STATUS, 5'd0, 32'h0040_0001, ALL);
      checkOutput();

      // Hardware interrupt path and int_req latency
`ifdef CP0_TIMER_INT_EN
      mtc0(5'd11, 32'hFFFF_0000);
`endif
      mtc0(5'd12, 32'h0000_8001);
      hw_int = 6'b100000;
      tick(1);
      pushExp("hw5_ip7", SEL_CAUSE, 5'd0, 32'h0000_8000, 32'h0000_FF00);
      pushExp("int_lat0", SEL_INT, 5'd0, 32'h0, 32'h1);
      checkOutput();
      tick(1);
      pushExp("int_set", SEL_INT, 5'd0, 32'h1, 32'h1);
      checkOutput();
      mtc0(5'd12, 32'h0000_8003);
      pushExp("int_exl_lat", SEL_INT, 5'd0, 32'h1, 32'h1);
      checkOutput();
      tick(1);
      pushExp("int_exl_off", SEL_INT, 5'd0, 32'h0, 32'h1);
      checkOutput();
      hw_int = 6'b000001;
      mtc0(5'd12, 32'h0000_0000);
      pushExp("hw0_ip2", SEL_CAUSE, 5'd0, 32'h0000_0400, 32'h0000_FF00);
      checkOutput();
      hw_int = 6'b000000;

`ifdef CP0_TIMER_INT_EN
      // Timer match across the Count wrap
      mtc0(5'd9, 32'hFFFF_FFFE);
      mtc0(5'd11, 32'h0000_0001);
      pushExp("ti_clear_wr", SEL_CAUSE, 5'd0, 32'h0, 32'h4000_0000);
      checkOutput();
      tick(3);
      pushExp("tm_count0", SEL_RD, 5'd9, 32'h0, ALL);
      checkOutput();
      tick(2);
      pushExp("tm_count1", SEL_RD, 5'd9, 32'h1, ALL);
      pushExp("ti_not_yet", SEL_CAUSE, 5'd0, 32'h0, 32'h4000_0000);
      checkOutput();
      tick(1);
      pushExp("ti_set", SEL_CAUSE, 5'd0, 32'h4000_0000, 32'h4000_0000);
      checkOutput();
      mtc0(5'd12, 32'h0000_8001);
      tick(1);
      pushExp("ti_int", SEL_INT, 5'd0, 32'h1, 32'h1);
      checkOutput();
      mtc0(5'd11, 32'h0000_1000);
      pushExp("ti_cleared", SEL_CAUSE, 5'd0, 32'h0, 32'h4000_0000);
      checkOutput();
      mtc0(5'd12, 32'h0000_0000);
`else
      // Without the timer, Compare is absent and Count passing 5 never sets TI
      mtc0(5'd11, 32'h0000_0005);
      pushExp("cmp_absent", SEL_RD, 5'd11, 32'h0, ALL);
      checkOutput();
      mtc0(5'd9, 32'h0000_0003);
      tick(8);
      pushExp("cnt_past5", SEL_RD, 5'd9, 32'h7, ALL);
      pushExp("no_ti", SEL_CAUSE, 5'd0, 32'h0, 32'h4000_0000);
      checkOutput();
`endif

      // Reset mid-operation
      rst = 1'b1;
      pushExp("mrst_status", SEL_STATUS, 5'd0, 32'h0040_0000, ALL);
      pushExp("mrst_count", SEL_RD, 5'd9, 32'h0, ALL);
      pushExp("mrst_badv", SEL_RD, 5'd8, 32'h0, ALL);
      pushExp("mrst_epc", SEL_EPC, 5'd0, 32'h0, ALL);
      pushExp("mrst_int", SEL_INT, 5'd0, 32'h0, 32'h1);
      checkOutput();
      tick(1);
      rst = 1'b0;
      tick(2);
      pushExp("mrst_resume", SEL_RD, 5'd9, 32'h1, ALL);
      checkOutput();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
